rom_dl_router: RTL and testbench
================================

ROM_DL_ROUTER -- requirements
Module: rom_dl_router

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, entries of buffered download bytes (power of two, 2..16).
REQ-002 SHALL have parameter SP_BASE, default 25'h10000, byte offset of sprite ROM region.
REQ-003 clk_mem  in  1  sole clock. Reset is asynchronous and active-high.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 ioctl_download, ioctl_wr  in  1 each  HPS download active and byte strobe; strobe is a level, edge-detected internally.
REQ-006 ioctl_addr  in  25  byte address; ioctl_dout  in  8  byte; ioctl_index  in  8  image index.
REQ-007 ioctl_wait  out  1  backpressure to HPS.
REQ-008 port1_req  out  1  toggle request; port1_ack  in  1  toggle ack; port1_a  out  23; port1_ds  out  2; port1_d  out  16.
REQ-009 port2_req, port2_ack, port2_a, port2_ds, port2_d: same widths and meaning as port1.
REQ-010 dl_wr  out  1; dl_addr  out  17; dl_data  out  8  on-chip BRAM/PROM write port.
REQ-011 rom_loaded  out  1  image fully committed.

Function
REQ-012 SHALL accept a byte on each rising edge of ioctl_wr while ioctl_download=1 and ioctl_index=0; other bytes SHALL be ignored.
REQ-013 Accepted {addr,data} SHALL enter a FIFO_DEPTH FIFO; ioctl_wait SHALL be 1 when occupancy >= FIFO_DEPTH-1, else 0.
REQ-014 A byte arriving with FIFO full SHALL be dropped and SHALL NOT corrupt queued entries.
REQ-015 Region decode at FIFO head: 0x00000-0x09FFF -> PORT1; 0x0A000-0x0FFFF and 0x1C000-0x1C31F -> BRAM; 0x10000-0x1BFFF -> PORT2; anything else -> discarded, popped in one cycle.
REQ-016 PORT1: port1_a=addr[23:1], port1_ds={addr[0],~addr[0]}, port1_d={data,data}.
REQ-017 PORT2, with s=addr-SP_BASE: port2_a={s[23:16],s[13:0],s[15]}, port2_ds={s[14],~s[14]}, port2_d={data,data}.
REQ-018 BRAM: dl_wr pulses exactly one cycle, dl_addr=addr[16:0], dl_data=data; pops same cycle.
REQ-019 Drain FSM states IDLE, ISSUE, WAIT_ACK, DONE.
REQ-020 IDLE->ISSUE when FIFO non-empty; ISSUE toggles the selected portN_req and drives address/data, then -> WAIT_ACK.
REQ-021 WAIT_ACK holds portN_a/ds/d stable until portN_ack==portN_req, then pops and -> IDLE; no timeout.
REQ-022 Only one SDRAM request SHALL be outstanding at a time; issue order SHALL equal acceptance order.
REQ-023 IDLE->DONE when ioctl_download has fallen, FIFO empty and no request outstanding; DONE sets rom_loaded=1.
REQ-024 Falling edge of ioctl_download coincident with a pending byte strobe SHALL still accept that byte.
REQ-025 Rising edge of ioctl_download SHALL clear rom_loaded and force DONE->IDLE.
REQ-026 Simultaneous FIFO push and pop SHALL keep occupancy unchanged.

Reset
REQ-027 Reset SHALL clear FIFO, force state IDLE, set port1_req=port2_req=0, dl_wr=0, ioctl_wait=0, rom_loaded=0, all address/data outputs to 0.
REQ-028 Reset mid-download SHALL abandon outstanding requests; the first post-reset request SHALL not toggle until portN_ack==portN_req.

Configuration
REQ-029 ROM_DL_CHECKSUM_EN defined: extra output dl_checksum [15:0], 16-bit wrap-around sum of every accepted byte, cleared on download rising edge and reset, valid when rom_loaded=1.
REQ-030 ROM_DL_CHECKSUM_EN undefined: no dl_checksum port and no adder logic.

Structure
REQ-031 Shared package rom_dl_pkg SHALL hold region base/limit constants, region enum (PORT1, PORT2, BRAM, DROP) and FSM state enum.
REQ-032 FIFO SHALL be sub-module dl_fifo (synchronous, single clock, parameterised depth/width).

Verification
REQ-033 Write 0x00000=0x12, 0x00001=0x34, acks looped back after 3 cycles -> two port1 toggles; a=0, ds=01 then 10, d=1212 then 3434; rom_loaded=1 after download ends.
REQ-034 Write 0x14001=0xAB -> port2_a={8'h00,14'h0001,1'b0}, ds=10, d=ABAB.
REQ-035 Write 0x1C305=0x7 -> single dl_wr pulse, dl_addr=0x1C305, dl_data=0x07; no port toggles.
REQ-036 Ack withheld, 6 strobes with FIFO_DEPTH=4 -> ioctl_wait=1 at occupancy 3; 5th stored; 6th dropped; issue order preserved on release.
REQ-037 ioctl_index=1 bytes and address 0x1D000 -> no port toggle, no dl_wr.
REQ-038 Reset asserted in WAIT_ACK -> all outputs at reset values next cycle; new download completes normally; with ROM_DL_CHECKSUM_EN, bytes 0xFF,0x02 give dl_checksum=0x0101.

Source files
------------

// File: rtl/rom_dl_pkg.sv
// rtl/rom_dl_pkg.sv - shared region map, region/state enums and head decode for rom_dl_router
package rom_dl_pkg;

    // Region limits (inclusive). PORT1 starts at byte 0.
    localparam logic [24:0] P1_LIMIT  = 25'h09FFF;
    localparam logic [24:0] BR0_BASE  = 25'h0A000;
    localparam logic [24:0] BR0_LIMIT = 25'h0FFFF;
    localparam logic [24:0] P2_BASE   = 25'h10000;
    localparam logic [24:0] P2_LIMIT  = 25'h1BFFF;
    localparam logic [24:0] BR1_BASE  = 25'h1C000;
    localparam logic [24:0] BR1_LIMIT = 25'h1C31F;

    typedef enum logic [1:0] {
        PORT1,
        PORT2,
        BRAM,
        DROP
    } region_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        DONE
    } state_e;

    function automatic region_e decode_region(input logic [24:0] addr);
        region_e rgn;
        if (addr <= P1_LIMIT) begin
            rgn = PORT1;
        end else if (addr >= BR0_BASE && addr <= BR0_LIMIT) begin
            rgn = BRAM;
        end else if (addr >= P2_BASE && addr <= P2_LIMIT) begin
            rgn = PORT2;
        end else if (addr >= BR1_BASE && addr <= BR1_LIMIT) begin
            rgn = BRAM;
        end else begin
            rgn = DROP;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/dl_fifo.sv
// rtl/dl_fifo.sv - single-clock FIFO for buffered download bytes; pushes while full are dropped
module dl_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage array: written only on an accepted push, so a full FIFO never overwrites queued entries.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers and occupancy; push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rom_dl_router.sv
// rtl/rom_dl_router.sv - routes HPS ROM download bytes to two SDRAM ports or BRAM; ROM_DL_CHECKSUM_EN adds dl_checksum
module rom_dl_router
    import rom_dl_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [24:0] SP_BASE    = 25'h10000
) (
    input  logic        clk_mem,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        dl_wr,
    output logic [16:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        rom_loaded
`ifdef ROM_DL_CHECKSUM_EN
    ,
    output logic [15:0] dl_checksum
`endif
);

    localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] WAIT_LVL = CW'(FIFO_DEPTH - 1);

    logic          wr_q;
    logic          dl_q;
    logic          fell_q;
    logic          wr_rise;
    logic          dl_rise;
    logic          dl_fall;
    logic          accept;
    logic          pop;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [32:0]   head;
    logic [24:0]   head_addr;
    logic [7:0]    head_data;
    logic [23:0]   sp_off;
    region_e       head_rgn;

    state_e        state_q, state_d;
    logic          sel_p2_q, sel_p2_d;
    logic          p1_req_q, p1_req_d;
    logic [22:0]   p1_a_q, p1_a_d;
    logic [1:0]    p1_ds_q, p1_ds_d;
    logic [15:0]   p1_d_q, p1_d_d;
    logic          p2_req_q, p2_req_d;
    logic [22:0]   p2_a_q, p2_a_d;
    logic [1:0]    p2_ds_q, p2_ds_d;
    logic [15:0]   p2_d_q, p2_d_d;
    logic          dl_wr_q, dl_wr_d;
    logic [16:0]   dl_addr_q, dl_addr_d;
    logic [7:0]    dl_data_q, dl_data_d;

    assign wr_rise = ioctl_wr && !wr_q;
    assign dl_rise = ioctl_download && !dl_q;
    assign dl_fall = !ioctl_download && dl_q;
    // dl_q keeps a strobe landing on the same cycle download drops inside the window.
    assign accept  = wr_rise && (ioctl_download || dl_q) && (ioctl_index == 8'd0);

    dl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk_i   (clk_mem),
        .rst_i   (reset),
        .push_i  (accept),
        .data_i  ({ioctl_addr, ioctl_dout}),
        .pop_i   (pop),
        .data_o  (head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_addr = head[32:8];
    assign head_data = head[7:0];
    assign head_rgn  = decode_region(head_addr);
    assign sp_off    = head_addr[23:0] - SP_BASE[23:0];

    assign ioctl_wait = (fifo_count >= WAIT_LVL);
    assign rom_loaded = (state_q == DONE);
    assign port1_req  = p1_req_q;
    assign port1_a    = p1_a_q;
    assign port1_ds   = p1_ds_q;
    assign port1_d    = p1_d_q;
    assign port2_req  = p2_req_q;
    assign port2_a    = p2_a_q;
    assign port2_ds   = p2_ds_q;
    assign port2_d    = p2_d_q;
    assign dl_wr      = dl_wr_q;
    assign dl_addr    = dl_addr_q;
    assign dl_data    = dl_data_q;

    // Strobe/download edge history and the "download has ended" flag.
    always_ff @(posedge clk_mem or posedge reset) begin
        if (reset) begin
            wr_q   <= 1'b0;
            dl_q   <= 1'b0;
            fell_q <= 1'b0;
        end else begin
            wr_q <= ioctl_wr;
            dl_q <= ioctl_download;
            if (dl_rise) begin
                fell_q <= 1'b0;
            end else if (dl_fall) begin
                fell_q <= 1'b1;
            end
        end
    end

    // Drain FSM. The head is popped when its request is issued; the port registers then hold
    // address/data stable until the ack, so the FIFO plus the in-flight entry buffer DEPTH+1 bytes.
    always_comb begin
        state_d   = state_q;
        sel_p2_d  = sel_p2_q;
        p1_req_d  = p1_req_q;
        p1_a_d    = p1_a_q;
        p1_ds_d   = p1_ds_q;
        p1_d_d    = p1_d_q;
        p2_req_d  = p2_req_q;
        p2_a_d    = p2_a_q;
        p2_ds_d   = p2_ds_q;
        p2_d_d    = p2_d_q;
        dl_wr_d   = 1'b0;
        dl_addr_d = dl_addr_q;
        dl_data_d = dl_data_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = ISSUE;
                end else if (fell_q && !ioctl_download) begin
                    state_d = DONE;
                end
            end
            ISSUE: begin
                case (head_rgn)
                    PORT1: begin
                        // A stale ack left over from before reset must settle before toggling.
                        if (port1_ack == p1_req_q) begin
                            p1_req_d = !p1_req_q;
                            p1_a_d   = head_addr[23:1];
                            p1_ds_d  = {head_addr[0], !head_addr[0]};
                            p1_d_d   = {head_data, head_data};
                            sel_p2_d = 1'b0;
                            pop      = 1'b1;
                            state_d  = WAIT_ACK;
                        end
                    end
                    PORT2: begin
                        if (port2_ack == p2_req_q) begin
                            p2_req_d = !p2_req_q;
                            p2_a_d   = {sp_off[23:16], sp_off[13:0], sp_off[15]};
                            p2_ds_d  = {sp_off[14], !sp_off[14]};
                            p2_d_d   = {head_data, head_data};
                            sel_p2_d = 1'b1;
                            pop      = 1'b1;
                            state_d  = WAIT_ACK;
                        end
                    end
                    BRAM: begin
                        dl_wr_d   = 1'b1;
                        dl_addr_d = head_addr[16:0];
                        dl_data_d = head_data;
                        pop       = 1'b1;
                        state_d   = IDLE;
                    end
                    default: begin
                        pop     = 1'b1;
                        state_d = IDLE;
                    end
                endcase
            end
            WAIT_ACK: begin
                if (sel_p2_q ? (port2_ack == p2_req_q) : (port1_ack == p1_req_q)) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (dl_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered port/BRAM outputs.
    always_ff @(posedge clk_mem or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_p2_q  <= 1'b0;
            p1_req_q  <= 1'b0;
            p1_a_q    <= '0;
            p1_ds_q   <= '0;
            p1_d_q    <= '0;
            p2_req_q  <= 1'b0;
            p2_a_q    <= '0;
            p2_ds_q   <= '0;
            p2_d_q    <= '0;
            dl_wr_q   <= 1'b0;
            dl_addr_q <= '0;
            dl_data_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_p2_q  <= sel_p2_d;
            p1_req_q  <= p1_req_d;
            p1_a_q    <= p1_a_d;
            p1_ds_q   <= p1_ds_d;
            p1_d_q    <= p1_d_d;
            p2_req_q  <= p2_req_d;
            p2_a_q    <= p2_a_d;
            p2_ds_q   <= p2_ds_d;
            p2_d_q    <= p2_d_d;
            dl_wr_q   <= dl_wr_d;
            dl_addr_q <= dl_addr_d;
            dl_data_q <= dl_data_d;
        end
    end

`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0] csum_q;

    assign dl_checksum = csum_q;

    // Running sum of accepted bytes, restarted when a new download begins.
    always_ff @(posedge clk_mem or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
        end else if (dl_rise) begin
            csum_q <= accept ? {8'h00, ioctl_dout} : 16'h0000;
        end else if (accept) begin
            csum_q <= csum_q + {8'h00, ioctl_dout};
        end
    end
`endif

endmodule

// File: tb/tb_rom_dl_router.sv
// tb/tb_rom_dl_router.sv - randomized self-checking bench for rom_dl_router against a region-map reference model
module tb_rom_dl_router;

    logic        clk_mem = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wait;
    logic        port1_req;
    logic        port1_ack = 1'b0;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port2_req;
    logic        port2_ack = 1'b0;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;
    logic        dl_wr;
    logic [16:0] dl_addr;
    logic [7:0]  dl_data;
    logic        rom_loaded;
`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0] dl_checksum;
`endif

    rom_dl_router #(
        .FIFO_DEPTH (4),
        .SP_BASE    (25'h10000)
    ) dut (
        .clk_mem        (clk_mem),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .port1_req      (port1_req),
        .port1_ack      (port1_ack),
        .port1_a        (port1_a),
        .port1_ds       (port1_ds),
        .port1_d        (port1_d),
        .port2_req      (port2_req),
        .port2_ack      (port2_ack),
        .port2_a        (port2_a),
        .port2_ds       (port2_ds),
        .port2_d        (port2_d),
        .dl_wr          (dl_wr),
        .dl_addr        (dl_addr),
        .dl_data        (dl_data),
        .rom_loaded     (rom_loaded)
`ifdef ROM_DL_CHECKSUM_EN
        ,
        .dl_checksum    (dl_checksum)
`endif
    );

    initial forever #5 clk_mem = ~clk_mem;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    logic [15:0] exp_sum = '0;
    bit          mon_en = 1'b0;
    bit          ack_en = 1'b1;
    bit          ack_rand = 1'b0;
    bit          hold_ack1 = 1'b0;
    bit          p1_prev = 1'b0;
    bit          p2_prev = 1'b0;
    int unsigned bnd[8] = '{32'h09FFF, 32'h0A000, 32'h0FFFF, 32'h10000,
                            32'h1BFFF, 32'h1C000, 32'h1C31F, 32'h1C320};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_ev(input int unsigned kind, input int unsigned a,
                                            input int unsigned ds, input int unsigned d);
        return (64'(kind) << 41) | (64'(a) << 18) | (64'(ds) << 16) | 64'(d);
    endfunction

    // Reference: what a stored byte should produce, straight from the region map.
    function automatic logic [63:0] model_ev(input int unsigned addr, input int unsigned data,
                                             output bit valid);
        int unsigned s;
        valid = 1'b1;
        if (addr < 32'hA000) begin
            return pack_ev(1, addr / 2, (addr % 2) ? 2 : 1, data * 257);
        end else if (addr < 32'h10000) begin
            return pack_ev(3, addr % 131072, 0, data);
        end else if (addr < 32'h1C000) begin
            s = addr - 32'h10000;
            return pack_ev(2, ((s / 65536) % 256) * 32768 + (s % 16384) * 2 + (s / 32768) % 2,
                           ((s / 16384) % 2) ? 2 : 1, data * 257);
        end else if (addr <= 32'h1C31F) begin
            return pack_ev(3, addr % 131072, 0, data);
        end
        valid = 1'b0;
        return '0;
    endfunction

    function automatic int unsigned next_lat();
        return ack_rand ? $urandom_range(1, 5) : 3;
    endfunction

    // SDRAM stand-in for port 1: loops req back to ack after a latency.
    initial forever begin
        @(negedge clk_mem);
        if (hold_ack1) begin
            port1_ack = 1'b1;
        end else if (ack_en && (port1_req !== port1_ack)) begin
            repeat (next_lat()) @(negedge clk_mem);
            port1_ack = port1_req;
        end
    end

    initial forever begin
        @(negedge clk_mem);
        if (ack_en && (port2_req !== port2_ack)) begin
            repeat (next_lat()) @(negedge clk_mem);
            port2_ack = port2_req;
        end
    end

    // Records every request toggle and BRAM write in the order they appear.
    initial forever begin
        @(negedge clk_mem);
        if (mon_en) begin
            if (port1_req !== p1_prev) obs_q.push_back(pack_ev(1, 32'(port1_a), 32'(port1_ds), 32'(port1_d)));
            if (port2_req !== p2_prev) obs_q.push_back(pack_ev(2, 32'(port2_a), 32'(port2_ds), 32'(port2_d)));
            if (dl_wr) obs_q.push_back(pack_ev(3, 32'(dl_addr), 0, 32'(dl_data)));
        end
        p1_prev = port1_req;
        p2_prev = port2_req;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_mem);
    endtask

    task automatic send_byte(input int unsigned addr, input int unsigned data, input int unsigned idx,
                             input bit last, input bit stored);
        logic [63:0] ev;
        bit          valid;
        ioctl_addr  = 25'(addr);
        ioctl_dout  = 8'(data);
        ioctl_index = 8'(idx);
        ioctl_wr    = 1'b1;
        if (last) ioctl_download = 1'b0;
        if (idx == 0) begin
            exp_sum += 16'(data);
            ev = model_ev(addr, data, valid);
            if (stored && valid) exp_q.push_back(ev);
        end
        tick(1);
        ioctl_wr = 1'b0;
        tick(1);
    endtask

    task automatic start_download();
        ioctl_download = 1'b1;
        exp_sum = '0;
        tick(2);
        check_eq("rom_loaded_clear", 64'(rom_loaded), 64'd0);
    endtask

    task automatic compare_events(input string tag);
        int n;
        check_eq({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic finish_download(input string tag, input bit chk_sum);
        ioctl_download = 1'b0;
        for (int i = 0; i < 3000 && !rom_loaded; i++) tick(1);
        check_eq({tag, "_loaded"}, 64'(rom_loaded), 64'd1);
        tick(2);
        compare_events(tag);
`ifdef ROM_DL_CHECKSUM_EN
        if (chk_sum) check_eq({tag, "_checksum"}, 64'(dl_checksum), 64'(exp_sum));
`else
        if (chk_sum) tick(0);
`endif
    endtask

    initial begin
        int unsigned addr;
        int unsigned r;
        tick(3);
        check_eq("reset_ctrl", 64'({port1_req, port2_req, dl_wr, ioctl_wait, rom_loaded}), 64'd0);
        check_eq("reset_data", 64'({port1_a, port1_ds, port1_d, dl_addr, dl_data}), 64'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick(2);

        // Two PORT1 bytes, 3-cycle ack loopback.
        start_download();
        send_byte(32'h0, 32'h12, 0, 1'b0, 1'b1);
        send_byte(32'h1, 32'h34, 0, 1'b0, 1'b1);
        finish_download("p1", 1'b1);

        // PORT2, ignored index, discarded region, then BRAM byte coincident with download falling.
        start_download();
        send_byte(32'h14001, 32'hAB, 0, 1'b0, 1'b1);
        send_byte(32'h00010, 32'h99, 1, 1'b0, 1'b1);
        send_byte(32'h1D000, 32'h55, 0, 1'b0, 1'b1);
        send_byte(32'h1C305, 32'h07, 0, 1'b1, 1'b1);
        finish_download("mix", 1'b1);

        // Backpressure: ack withheld; one byte in flight plus four queued, sixth dropped.
        ack_en = 1'b0;
        start_download();
        for (int k = 1; k <= 6; k++) begin
            send_byte(32'(k - 1), 32'(8'h10 * k), 0, 1'b0, k != 6);
            tick(3);
            check_eq($sformatf("bp_wait_%0d", k), 64'(ioctl_wait), 64'(k >= 4));
        end
        check_eq("bp_inflight", 64'(obs_q.size()), 64'd1);
        ack_en = 1'b1;
        finish_download("bp", 1'b0);

        // Randomized mix honouring ioctl_wait.
        ack_rand = 1'b1;
        start_download();
        for (int n = 0; n < 40; n++) begin
            for (int w = 0; w < 200 && ioctl_wait; w++) tick(1);
            if (ioctl_wait) check_eq("rand_wait_release", 64'(ioctl_wait), 64'd0);
            r = $urandom_range(0, 5);
            case (r)
                0: addr = $urandom_range(0, 32'h9FFF);
                1: addr = $urandom_range(32'hA000, 32'hFFFF);
                2: addr = $urandom_range(32'h10000, 32'h1BFFF);
                3: addr = $urandom_range(32'h1C000, 32'h1C31F);
                4: addr = $urandom_range(32'h1C320, 32'h1FFFFFF);
                default: addr = bnd[$urandom_range(0, 7)];
            endcase
            send_byte(addr, $urandom_range(0, 255), ($urandom_range(0, 7) == 0) ? 1 : 0, 1'b0, 1'b1);
            tick($urandom_range(0, 2));
        end
        finish_download("rand", 1'b1);
        ack_rand = 1'b0;

        // Reset while a request waits for its ack, then a stale ack must hold off the next request.
        ack_en = 1'b0;
        start_download();
        send_byte(32'h100, 32'h5A, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && (port1_req == port1_ack); i++) tick(1);
        check_eq("rst_outstanding", 64'(port1_req ^ port1_ack), 64'd1);
        mon_en = 1'b0;
        reset = 1'b1;
        ioctl_download = 1'b0;
        hold_ack1 = 1'b1;
        tick(1);
        check_eq("rst_ctrl", 64'({port1_req, port2_req, dl_wr, ioctl_wait, rom_loaded}), 64'd0);
        check_eq("rst_p1", 64'({port1_a, port1_ds, port1_d}), 64'd0);
        check_eq("rst_p2", 64'({port2_a, port2_ds, port2_d}), 64'd0);
        check_eq("rst_bram", 64'({dl_addr, dl_data}), 64'd0);
        obs_q.delete();
        exp_q.delete();
        tick(1);
        reset = 1'b0;
        mon_en = 1'b1;
        tick(1);
        start_download();
        send_byte(32'hA000, 32'hFF, 0, 1'b0, 1'b1);
        send_byte(32'h2, 32'h02, 0, 1'b0, 1'b1);
        tick(10);
        check_eq("rst_stale_hold", 64'(port1_req), 64'd0);
        hold_ack1 = 1'b0;
        ack_en = 1'b1;
        finish_download("rst", 1'b1);
`ifdef ROM_DL_CHECKSUM_EN
        check_eq("rst_checksum_0101", 64'(dl_checksum), 64'h0101);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
